// File: rtl/fp_add_align_ctrl_pipe.sv
// rtl/fp_add_align_ctrl_pipe.sv - FP-adder alignment control: swap, saturated shift, effective op and
// result sign, registered behind a one-deep valid/ready stage.
module fp_add_align_ctrl_pipe #(
  parameter int EXPO_WIDTH = 8,
  parameter int MANT_WIDTH = 23,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXPO_WIDTH-1:0] exp_a_in,
  input  logic [EXPO_WIDTH-1:0] exp_b_in,
  input  logic [MANT_WIDTH-1:0] mant_a_in,
  input  logic [MANT_WIDTH-1:0] mant_b_in,
  input  logic                  sign_a_in,
  input  logic                  sign_b_in,
  input  logic                  op_sub_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  swap_out,
  output logic [EXPO_WIDTH-1:0] larger_exp_out,
  output logic [EXPO_WIDTH-1:0] rshift_out,
  output logic                  shift_sat_out,
  output logic                  eff_sub_out,
  output logic                  result_sign_out,
  output logic                  zero_result_out,
  output logic [TAG_WIDTH-1:0]  tag_out
);

  // Shifting past hidden + guard + round + sticky only feeds sticky, so clip there.
  localparam logic [EXPO_WIDTH-1:0] SAT = EXPO_WIDTH'(MANT_WIDTH + 3);

  logic [EXPO_WIDTH:0]   w_diff;
  logic [EXPO_WIDTH:0]   w_diff_neg;
  logic [EXPO_WIDTH-1:0] w_mag;
  logic                  w_exp_eq;
  logic                  w_swap;
  logic                  w_sat;
  logic                  w_eff_sub;
  logic                  w_zero;
  logic                  w_sign;
  logic                  w_accept;

  logic                  r_out_valid;
  logic                  r_swap;
  logic [EXPO_WIDTH-1:0] r_larger_exp;
  logic [EXPO_WIDTH-1:0] r_rshift;
  logic                  r_shift_sat;
  logic                  r_eff_sub;
  logic                  r_result_sign;
  logic                  r_zero_result;
  logic [TAG_WIDTH-1:0]  r_tag;

  assign w_diff     = {1'b0, exp_a_in} - {1'b0, exp_b_in};
  assign w_diff_neg = -w_diff;
  assign w_exp_eq   = (w_diff == '0);
  assign w_swap     = w_diff[EXPO_WIDTH] | (w_exp_eq & (mant_b_in > mant_a_in));
  assign w_mag      = w_diff[EXPO_WIDTH] ? w_diff_neg[EXPO_WIDTH-1:0] : w_diff[EXPO_WIDTH-1:0];
  assign w_sat      = (w_mag > SAT);
  assign w_eff_sub  = sign_a_in ^ sign_b_in ^ op_sub_in;
  assign w_zero     = w_eff_sub & w_exp_eq & (mant_a_in == mant_b_in);
  // Exact cancellation yields +0 under round-to-nearest.
  assign w_sign     = w_zero ? 1'b0 : (w_swap ? (sign_b_in ^ op_sub_in) : sign_a_in);

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_swap        <= 1'b0;
      r_larger_exp  <= '0;
      r_rshift      <= '0;
      r_shift_sat   <= 1'b0;
      r_eff_sub     <= 1'b0;
      r_result_sign <= 1'b0;
      r_zero_result <= 1'b0;
      r_tag         <= '0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_swap        <= w_swap;
      r_larger_exp  <= w_swap ? exp_b_in : exp_a_in;
      r_rshift      <= w_sat ? SAT : w_mag;
      r_shift_sat   <= w_sat;
      r_eff_sub     <= w_eff_sub;
      r_result_sign <= w_sign;
      r_zero_result <= w_zero;
      r_tag         <= tag_in;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign swap_out        = r_swap;
  assign larger_exp_out  = r_larger_exp;
  assign rshift_out      = r_rshift;
  assign shift_sat_out   = r_shift_sat;
  assign eff_sub_out     = r_eff_sub;
  assign result_sign_out = r_result_sign;
  assign zero_result_out = r_zero_result;
  assign tag_out         = r_tag;

endmodule

// File: tb/tb_fp_add_align_ctrl_pipe.sv
// tb/tb_fp_add_align_ctrl_pipe.sv - directed and random checks of fp_add_align_ctrl_pipe against an
// arithmetic reference model with an expected-result queue.
module tb_fp_add_align_ctrl_pipe;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int TW = 4;

  typedef struct {
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic          sa, sb, op;
    logic [TW-1:0] tag;
  } pair_t;

  typedef struct {
    logic          swap;
    logic [EW-1:0] larger;
    logic [EW-1:0] rshift;
    logic          sat, eff, sign, zero;
    logic [TW-1:0] tag;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [EW-1:0] exp_a_in = '0, exp_b_in = '0;
  logic [MW-1:0] mant_a_in = '0, mant_b_in = '0;
  logic sign_a_in = 1'b0, sign_b_in = 1'b0, op_sub_in = 1'b0;
  logic [TW-1:0] tag_in = '0;
  logic out_valid, out_ready = 1'b0;
  logic swap_out, shift_sat_out, eff_sub_out, result_sign_out, zero_result_out;
  logic [EW-1:0] larger_exp_out, rshift_out;
  logic [TW-1:0] tag_out;

  fp_add_align_ctrl_pipe #(.EXPO_WIDTH(EW), .MANT_WIDTH(MW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a_in(exp_a_in), .exp_b_in(exp_b_in), .mant_a_in(mant_a_in), .mant_b_in(mant_b_in),
    .sign_a_in(sign_a_in), .sign_b_in(sign_b_in), .op_sub_in(op_sub_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .swap_out(swap_out),
    .larger_exp_out(larger_exp_out), .rshift_out(rshift_out), .shift_sat_out(shift_sat_out),
    .eff_sub_out(eff_sub_out), .result_sign_out(result_sign_out),
    .zero_result_out(zero_result_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  res_t q[$];
  bit   lit_valid = 1'b0;
  res_t lit;

  // Reference: signed integer exponent difference, magnitude ordering, sign rules.
  function automatic res_t model(pair_t p);
    res_t r;
    int d, mag;
    d = int'(p.ea) - int'(p.eb);
    mag = (d < 0) ? -d : d;
    r.swap   = (d < 0) || (d == 0 && p.mb > p.ma);
    r.larger = r.swap ? p.eb : p.ea;
    r.sat    = (mag > MW + 3);
    r.rshift = r.sat ? EW'(MW + 3) : EW'(mag);
    r.eff    = p.sa ^ p.sb ^ p.op;
    r.zero   = r.eff && (d == 0) && (p.ma == p.mb);
    if (r.zero)      r.sign = 1'b0;
    else if (r.swap) r.sign = p.sb ^ p.op;
    else             r.sign = p.sa;
    r.tag = p.tag;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_res(res_t e);
    chk("swap", swap_out, e.swap);
    chk("larger_exp", larger_exp_out, e.larger);
    chk("rshift", rshift_out, e.rshift);
    chk("shift_sat", shift_sat_out, e.sat);
    chk("eff_sub", eff_sub_out, e.eff);
    chk("result_sign", result_sign_out, e.sign);
    chk("zero_result", zero_result_out, e.zero);
    chk("tag", tag_out, e.tag);
  endtask

  task automatic chk_all_zero();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_swap", swap_out, 0);
    chk("rst_larger", larger_exp_out, 0);
    chk("rst_rshift", rshift_out, 0);
    chk("rst_sat", shift_sat_out, 0);
    chk("rst_eff", eff_sub_out, 0);
    chk("rst_sign", result_sign_out, 0);
    chk("rst_zero", zero_result_out, 0);
    chk("rst_tag", tag_out, 0);
  endtask

  // One cycle: drive at the falling edge, check held state, then book any accept.
  task automatic tick(bit rdy, bit vld, pair_t p);
    @(negedge clk);
    out_ready = rdy; in_valid = vld;
    exp_a_in = p.ea; exp_b_in = p.eb; mant_a_in = p.ma; mant_b_in = p.mb;
    sign_a_in = p.sa; sign_b_in = p.sb; op_sub_in = p.op; tag_in = p.tag;
    #1;
    chk("in_ready", in_ready, (!out_valid || rdy) ? 1 : 0);
    chk("held_count", q.size(), out_valid ? 1 : 0);
    if (out_valid && q.size() > 0) begin
      chk_res(q[0]);
      if (rdy) void'(q.pop_front());
    end
    if (vld && in_ready) begin
      q.push_back(lit_valid ? lit : model(p));
      lit_valid = 1'b0;
    end
  endtask

  function automatic pair_t mk(int ea, int eb, int ma, int mb, bit sa, bit sb, bit op, int tag);
    pair_t p;
    p.ea = EW'(ea); p.eb = EW'(eb); p.ma = MW'(ma); p.mb = MW'(mb);
    p.sa = sa; p.sb = sb; p.op = op; p.tag = TW'(tag);
    return p;
  endfunction

  function automatic res_t mkr(bit sw, int lg, int sh, bit st, bit ef, bit sg, bit zr, int tag);
    res_t r;
    r.swap = sw; r.larger = EW'(lg); r.rshift = EW'(sh); r.sat = st;
    r.eff = ef; r.sign = sg; r.zero = zr; r.tag = TW'(tag);
    return r;
  endfunction

  task automatic directed(pair_t p, res_t e);
    lit = e; lit_valid = 1'b1;
    tick(1, 1, p);
    tick(1, 0, p);
    tick(1, 0, p);
  endtask

  pair_t idle;
  pair_t rp;
  int    ea, eb;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero();
    @(negedge clk);
    rst_n = 1'b1;

    directed(mk(8'h85, 8'h82, 0, 0, 0, 0, 0, 1), mkr(0, 8'h85, 3, 0, 0, 0, 0, 1));
    directed(mk(8'h10, 8'h90, 0, 0, 0, 1, 0, 2), mkr(1, 8'h90, 26, 1, 1, 1, 0, 2));
    directed(mk(8'h1A, 8'h00, 0, 0, 0, 0, 0, 3), mkr(0, 8'h1A, 26, 0, 0, 0, 0, 3));
    directed(mk(8'h3B, 8'h20, 5, 7, 0, 0, 0, 4), mkr(0, 8'h3B, 26, 1, 0, 0, 0, 4));
    directed(mk(8'h7F, 8'h7F, 24'h100000, 24'h200000, 0, 0, 1, 5),
             mkr(1, 8'h7F, 0, 0, 1, 1, 0, 5));
    directed(mk(8'h80, 8'h80, 24'h0ABCDE, 24'h0ABCDE, 1, 1, 1, 6),
             mkr(0, 8'h80, 0, 0, 1, 0, 1, 6));

    // Backpressure: tag 1 stalls two cycles while tag 2 waits upstream.
    tick(1, 1, mk(8'h40, 8'h41, 1, 2, 0, 1, 1, 1));
    tick(0, 1, mk(8'h22, 8'h20, 3, 3, 1, 0, 0, 2));
    tick(0, 1, mk(8'h22, 8'h20, 3, 3, 1, 0, 0, 2));
    tick(1, 1, mk(8'h22, 8'h20, 3, 3, 1, 0, 0, 2));
    tick(1, 1, mk(8'h05, 8'hF0, 9, 1, 1, 1, 0, 3));
    tick(1, 0, idle);
    tick(1, 0, idle);
    chk("bp_drained", q.size(), 0);

    // Reset while tag 5 is held.
    tick(1, 1, mk(8'h60, 8'h50, 4, 4, 0, 0, 0, 5));
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_tag", tag_out, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero();
    q.delete();
    tick(1, 1, mk(8'h33, 8'h31, 6, 2, 1, 0, 1, 7));
    tick(1, 0, idle);
    tick(1, 0, idle);

    for (int i = 0; i < 400; i++) begin
      ea = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0: eb = ea;
        1: eb = (ea + $urandom_range(24, 29)) & 8'hFF;
        2: eb = (ea - $urandom_range(0, 4)) & 8'hFF;
        default: eb = $urandom_range(0, 255);
      endcase
      rp = mk(ea, eb, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rp.mb = rp.ma;
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rp);
    end
    repeat (3) tick(1, 0, idle);
    chk("final_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
